// File: rtl/pipelined_addsub.sv
// Signed/unsigned adder-subtractor whose carry chain is cut into SEG-bit segments, one
// register stage per segment. All stages shift or hold together under a valid/ready handshake.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int NSTAGES = WIDTH / SEG;

  logic             advance;
  logic             out_valid_q;
  logic             cout_q;
  logic             overflow_q;
  logic             zero_q;
  logic [WIDTH-1:0] sum_q;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : stg
      // REM: operand bits not yet resolved on entry; DONE: result bits resolved on exit
      localparam int REM  = WIDTH - gi * SEG;
      localparam int DONE = (gi + 1) * SEG;

      logic [REM-1:0]  a_in;
      logic [REM-1:0]  bx_in;
      logic            c_in;
      logic            sat_in;
      logic            vld_in;
      logic [SEG:0]    seg_sum;
      logic [DONE-1:0] r_new;

      assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, bx_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

      if (gi == 0) begin : g_first
        // Subtraction folds into the adder: invert B here, carry-in of stage 0 is op.
        assign a_in   = a;
        assign bx_in  = b ^ {WIDTH{op}};
        assign c_in   = op;
        assign sat_in = sat;
        assign vld_in = in_valid;
        assign r_new  = seg_sum[SEG-1:0];
      end else begin : g_chain
        assign a_in   = stg[gi-1].g_mid.a_hi_q;
        assign bx_in  = stg[gi-1].g_mid.bx_hi_q;
        assign c_in   = stg[gi-1].g_mid.c_q;
        assign sat_in = stg[gi-1].g_mid.sat_q;
        assign vld_in = stg[gi-1].g_mid.vld_q;
        assign r_new  = {seg_sum[SEG-1:0], stg[gi-1].g_mid.r_q};
      end

      if (gi < NSTAGES - 1) begin : g_mid
        logic [REM-SEG-1:0] a_hi_q;
        logic [REM-SEG-1:0] bx_hi_q;
        logic [DONE-1:0]    r_q;
        logic               c_q;
        logic               sat_q;
        logic               vld_q;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_hi_q  <= '0;
            bx_hi_q <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            sat_q   <= 1'b0;
            vld_q   <= 1'b0;
          end else if (advance) begin
            a_hi_q  <= a_in[REM-1:SEG];
            bx_hi_q <= bx_in[REM-1:SEG];
            r_q     <= r_new;
            c_q     <= seg_sum[SEG];
            sat_q   <= sat_in;
            vld_q   <= vld_in;
          end
        end
      end else begin : g_last
        logic             msb_cin;
        logic             ovf_w;
        logic [WIDTH-1:0] res_w;

        // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
        assign msb_cin = a_in[SEG-1] ^ bx_in[SEG-1] ^ r_new[WIDTH-1];
        assign ovf_w   = msb_cin ^ seg_sum[SEG];

        always_comb begin
          res_w = r_new;
          if (sat_in && ovf_w) begin
            res_w = a_in[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
          end else if (advance) begin
            out_valid_q <= vld_in;
            if (vld_in) begin
              sum_q      <= res_w;
              cout_q     <= seg_sum[SEG];
              overflow_q <= ovf_w;
              zero_q     <= (res_w == '0);
            end
          end
        end
      end
    end
  endgenerate
endmodule
